// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared ROB widths, invalid-tag value and entry layout
package rob_pkg;

  localparam int TAG_W     = 4;
  localparam int DATA_W    = 32;
  localparam int OP_TYPE_W = 4;
  localparam int RD_W      = 5;

  localparam logic [TAG_W-1:0] TAG_INVALID = '1;

  typedef struct packed {
    logic                 busy;
    logic                 ready;
    logic [RD_W-1:0]      rd;
    logic [OP_TYPE_W-1:0] op;
    logic [DATA_W-1:0]    data;
  } rob_entry_t;

endpackage

// File: rtl/rob.sv
// rtl/rob.sv - reorder buffer: tag allocation, CDB capture, in-order commit
module rob #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = rob_pkg::TAG_W,
  parameter int DATA_W = rob_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          alloc_valid,
  input  logic [4:0]                    alloc_rd,
  input  logic [rob_pkg::OP_TYPE_W-1:0] alloc_op,
  output logic [TAG_W-1:0]              avail_tag,
  output logic                          full,
  input  logic                          cdb_valid,
  input  logic [TAG_W-1:0]              cdb_tag,
  input  logic [DATA_W-1:0]             cdb_data,
  output logic                          wb_valid,
  output logic [TAG_W-1:0]              wb_tag,
  output logic [4:0]                    wb_rd,
  output logic [DATA_W-1:0]             wb_data
);
  import rob_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] TAG_INV = '1;

  rob_entry_t entries_q [DEPTH];
  rob_entry_t entries_d [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic             alloc_fire;
  logic             cdb_hit;
  logic             commit_fire;
  logic [PTR_W-1:0] cdb_idx;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign avail_tag = TAG_W'(tail_q);
  assign wb_valid  = wb_valid_q;
  assign wb_tag    = wb_tag_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

  assign cdb_idx     = cdb_tag[PTR_W-1:0];
  assign alloc_fire  = alloc_valid && !full;
  // Tags at or above DEPTH never name a live entry, so they are dropped too.
  assign cdb_hit     = cdb_valid && (cdb_tag != TAG_INV) && (cdb_tag < TAG_W'(DEPTH)) &&
                       entries_q[cdb_idx].busy && !entries_q[cdb_idx].ready;
  assign commit_fire = entries_q[head_q].busy && entries_q[head_q].ready;

  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    wb_valid_d = 1'b0;
    wb_tag_d   = TAG_INV;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].busy  = 1'b0;
        entries_d[i].ready = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Alloc targets a free slot and commit a ready one, so the three
      // updates below never touch the same field of the same entry.
      if (alloc_fire) begin
        entries_d[tail_q].busy  = 1'b1;
        entries_d[tail_q].ready = 1'b0;
        entries_d[tail_q].rd    = alloc_rd;
        entries_d[tail_q].op    = alloc_op;
        tail_d                  = tail_q + PTR_W'(1);
      end
      if (cdb_hit) begin
        entries_d[cdb_idx].ready = 1'b1;
        entries_d[cdb_idx].data  = cdb_data;
      end
      if (commit_fire) begin
        entries_d[head_q].busy  = 1'b0;
        entries_d[head_q].ready = 1'b0;
        wb_valid_d              = 1'b1;
        wb_tag_d                = TAG_W'(head_q);
        wb_rd_d                 = entries_q[head_q].rd;
        wb_data_d               = entries_q[head_q].data;
        head_d                  = head_q + PTR_W'(1);
      end
      if (alloc_fire && !commit_fire) begin
        count_d = count_q + (PTR_W+1)'(1);
      end else if (commit_fire && !alloc_fire) begin
        count_d = count_q - (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_tag_q   <= TAG_INV;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      entries_q  <= entries_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wb_valid_q <= wb_valid_d;
      wb_tag_q   <= wb_tag_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

endmodule

// File: doc/rob.md
# rob

Reorder buffer that answers the decode stage's ROB-position requests and retires results in program order. It hands out the next free tag and raises `full`. It captures completed results from the common data bus (CDB) and drives the in-order writeback bus consumed by the register file and the decode forwarding mux. It sits between decode/issue and the register file, owning tag lifetime from allocation to commit.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, at most 15.
- `TAG_W`, 4: tag width; the all-ones value is `TAG_INVALID`.
- `DATA_W`, 32: result width.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `flush`  in  1: synchronous squash of all entries (mispredict recovery).
- `alloc_valid`  in  1: decode requests an entry this cycle (tag token).
- `alloc_rd`  in  5: destination register of the allocating instruction.
- `alloc_op`  in  `OP_TYPE_W`: op type, stored for debug/commit.
- `avail_tag`  out  `TAG_W`: tag the next allocation will receive, equal to the tail index.
- `full`  out  1: high when all entries are occupied.
- `cdb_valid`  in  1: a result is being broadcast.
- `cdb_tag`  in  `TAG_W`: tag of the result.
- `cdb_data`  in  `DATA_W`: result value.
- `wb_valid`  out  1: a commit is presented this cycle.
- `wb_tag`  out  `TAG_W`: tag being retired; the register file clears the matching rename.
- `wb_rd`  out  5: architectural destination; 0 means no register write.
- `wb_data`  out  `DATA_W`: committed value.

## Operation
Per-entry state:
- `busy`, `ready`, `rd`, `op`, `data`.
- Pointers `head` and `tail` are log2(DEPTH) bits and wrap modulo DEPTH.
- `count` is log2(DEPTH)+1 bits.

Derived outputs:
- `full` = (`count` == DEPTH), combinational from registers.
- `avail_tag` = `tail`, zero-extended to `TAG_W`.

Allocate, when `alloc_valid && !full`:
- Entry[`tail`] takes `busy`=1, `ready`=0, `rd`, `op`.
- `tail` increments.
- When `full` is high, `alloc_valid` is ignored; no entry is written and no pointer moves.

CDB capture, when `cdb_valid`, `cdb_tag` != `TAG_INVALID`, and entry[`cdb_tag`] is busy and not ready:
- Store `data` and set `ready`.
- A CDB hit on a non-busy entry, or on an entry that is already ready, is ignored.

Commit, when entry[`head`] is both `busy` and `ready`:
- Register `wb_valid`=1, `wb_tag`=`head`, `wb_rd`, `wb_data`.
- Clear `busy`; increment `head`.
- Otherwise `wb_valid`=0 next cycle, and `wb_tag` is driven to `TAG_INVALID`.
- At most one commit per cycle.

`count` update:
- +1 on an allocate only, −1 on a commit only.
- Unchanged on simultaneous allocate and commit.

Flush:
- Clears all `busy`/`ready` bits and sets `head`=`tail`=`count`=0.
- Drives `wb_valid`=0 and `wb_tag`=`TAG_INVALID` on the next cycle.
- Takes priority over allocate, CDB capture and commit in the same cycle.

Reset value of outputs: `full`=0, `avail_tag`=0, `wb_valid`=0, `wb_tag`=`TAG_INVALID`, `wb_rd`=0, `wb_data`=0. All state is cleared.

## Timing
- Allocate → tag consumed: the tag is visible on `avail_tag` before the edge and is owned by the instruction after the edge. `avail_tag` advances in the following cycle.
- CDB → commit:
  - Edge k sets `ready`.
  - Edge k+1 commits, if the entry is at the head.
  - `wb_*` is valid in the cycle after edge k+1.
  - There is no same-cycle CDB-to-commit bypass.
- Full with simultaneous commit: `full` is evaluated from pre-edge `count`, so a request in that cycle is refused. The slot becomes available on the next cycle.
- Wrap-around: `tail` going DEPTH−1 → 0 and `head` going DEPTH−1 → 0 are seamless; `count` disambiguates full from empty.
- Asynchronous `rst` mid-operation returns every output to its reset value immediately. No partial commit is emitted.

## Structure
- The shared package holds `TAG_W`, `TAG_INVALID`, `OP_TYPE_W` and the `rob_entry_t` struct (busy, ready, rd, op, data).
- Entry storage is a single register array inside `rob`. No sub-module; the allocation, capture and commit logic is one module.

## Test plan
- Reset, then allocate 3 entries (rd=1,2,3) → `avail_tag` steps 0,1,2,3; `full`=0; `wb_valid` stays 0.
- CDB tag 1 data 0xAA, then tag 0 data 0x55 → commits in order: tag0/rd1/0x55, then tag1/rd2/0xAA, each one cycle after the head becomes ready.
- Allocate 8 with no CDB → `full`=1 after the 8th edge. A 9th request leaves `tail` at 0. CDB tag 0 → commit, `full` drops. The next allocation gets tag 0 (wrap-around).
- Full ROB with head ready and `alloc_valid` high in the same cycle → commit occurs, allocation refused, `count` goes 8→7.
- 4 entries busy, `flush` plus `cdb_valid` tag 0 in the same cycle → all cleared, no `wb_valid`, `avail_tag`=0.
- Assert `rst` while `wb_valid`=1 → `wb_valid` falls immediately and `wb_tag`=`TAG_INVALID`.
